mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer that shares the processor's single-ported 16-bit memory between instruction fetch and the data load/store path driven by the decoder's `read_en_d`/`write_en_d` strobes. It sits between the fetch unit, the load/store path and the memory macro. It serializes accesses through a request/acknowledge handshake with variable-latency memory, gives data accesses priority with a starvation guard for fetch, and raises `stall` to freeze the PC while a data access is outstanding.

## Interface
- `AW`, 9, memory address width; matches the 9-bit jump/address field.
- `DW`, 16, data width.
- `MAX_DATA`, 4, consecutive data grants allowed while fetch waits; range 1..15.
- `TIMEOUT`, 15, cycles to wait for `mem_ack` when `MEM_TIMEOUT_EN` is defined; range 1..255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until `if_done`.
- `if_addr`  in  AW  fetch address.
- `if_done`  out  1  one-cycle pulse: fetch complete, `if_rdata` valid.
- `if_rdata`  out  DW  fetched instruction.
- `d_rd_en`  in  1  load request; held until `d_done`.
- `d_wr_en`  in  1  store request; held until `d_done`.
- `d_addr`  in  AW  data address.
- `d_wdata`  in  DW  store data.
- `d_done`  out  1  one-cycle pulse: data access complete.
- `d_rdata`  out  DW  load data.
- `stall`  out  1  PC freeze.
- `mem_req`  out  1  memory request; held until ack.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  write data.
- `mem_ack`  in  1  memory completion; read data valid in the same cycle.
- `mem_rdata`  in  DW  memory read data.
- `err`  out  1  one-cycle pulse on timeout abort.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Samples requests. If any request is present, latch the owner (FETCH or DATA), `mem_addr`, `mem_we` and `mem_wdata`, and go to BUSY. Otherwise stay in IDLE.
  - Data request means `d_rd_en | d_wr_en`. When both are high, the access is a write and the read is ignored.
- Priority:
  - DATA wins over FETCH.
  - Starvation counter `dcnt`, 4 bits: incremented on each DATA grant while `if_req` is high. It clears on a FETCH grant or whenever `if_req` is low.
  - When `dcnt == MAX_DATA` and both requests are present, FETCH wins.
- BUSY:
  - `mem_req` = 1 with latched address/data held stable.
  - On `mem_ack`, capture `mem_rdata` into the owner's rdata register, then go to RESP.
- RESP:
  - Pulse the owner's `_done` for one cycle, then go to IDLE.
  - The requester must present its request low in the cycle after `_done`. If it does not, the request is treated as new.
- `if_rdata`/`d_rdata` hold their value until the next completed read for that owner. A write leaves `d_rdata` unchanged.
- `stall` = `(d_rd_en | d_wr_en) & ~d_done`, combinational; forced 0 while `rst_n` is low.
- Input changes during BUSY/RESP are ignored; latched values are used.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE; `dcnt` and timeout counter clear.
  - `mem_req`, `mem_we`, `if_done`, `d_done` and `err` go to 0.
  - `mem_addr`, `mem_wdata`, `if_rdata` and `d_rdata` go to 0.
  - An in-flight access is dropped with no done pulse. After reset release, the first IDLE cycle samples requests.
- Latency:
  - Request seen in IDLE at cycle 0 → `mem_req` high from cycle 1.
  - Ack in cycle k ≥ 1 → `_done` in cycle k+1.
  - With a zero-wait memory (ack in the first `mem_req` cycle), done arrives in cycle 2. Back-to-back accesses complete every 3 cycles.
- All outputs except `stall` are registered.
- `mem_ack` outside BUSY is ignored.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - BUSY runs an 8-bit cycle counter, cleared on entry.
  - If no `mem_ack` arrives within `TIMEOUT` BUSY cycles, drop `mem_req`, load the owner's rdata with all ones (`16'hFFFF`), pulse `err` together with the owner's `_done` in RESP, and return to IDLE.
- `MEM_TIMEOUT_EN` undefined:
  - BUSY waits indefinitely.
  - `err` is tied to 0 and no counter is built.

## Test plan
- Fetch only: `if_req`=1, `if_addr`=9'h010, memory acks in the first `mem_req` cycle with 16'h1235 → `mem_req`/`mem_we`=1/0 at cycle 1, `if_done`=1 and `if_rdata`=16'h1235 at cycle 2.
- Store vs. fetch collision: `d_wr_en`=1, `d_addr`=9'h0A0, `d_wdata`=16'hBEEF and `if_req`=1 in the same IDLE cycle → write granted first (`mem_we`=1, `mem_wdata`=16'hBEEF); `stall`=1 until `d_done`; fetch is served next.
- Starvation: `if_req` held, 6 back-to-back loads, `MAX_DATA`=4 → grant order D,D,D,D,F,D,D.
- Wait states: ack delayed 3 cycles → `mem_req`, `mem_addr` and `mem_wdata` stable for 3 cycles, `d_done` one cycle after ack, `d_rdata`=ack data; a stray `mem_ack` in IDLE causes no change.
- Reset mid-access: assert `rst_n`=0 while in BUSY → `mem_req` drops immediately, no done pulse, all registered outputs 0; after release, a pending fetch is re-granted.
- Timeout (`MEM_TIMEOUT_EN`, `TIMEOUT`=15): load with no ack → `mem_req` drops after 15 cycles; `d_done`=`err`=1 in the same cycle; `d_rdata`=16'hFFFF.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch and the data
// load/store path. Accesses are serialized through a three-state sequencer
// (IDLE -> BUSY -> RESP). Data wins over fetch. A starvation counter hands
// the port to fetch after MAX_DATA consecutive data grants that fetch sat
// through. While a data access is pending, stall freezes the PC.
//
// Handshake semantics (all ports):
//   Requesters hold if_req / d_rd_en / d_wr_en high until their one-cycle
//   *_done pulse. They must drop the request in the cycle after the pulse,
//   or it is taken as a new request.
//   The memory side holds mem_req high with stable mem_addr/mem_we/mem_wdata
//   until mem_ack. mem_rdata is valid in the mem_ack cycle.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   if_req/if_addr         fetch request and address
//   if_done/if_rdata       fetch completion pulse and instruction word
//   d_rd_en/d_wr_en        load / store request (write wins when both high)
//   d_addr/d_wdata         data address and store data
//   d_done/d_rdata         data completion pulse and load data
//   stall                  combinational PC freeze
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata  memory macro port
//   err                    one-cycle pulse when an access is aborted on timeout
//
// Optional feature: define MEM_TIMEOUT_EN to abort BUSY after TIMEOUT cycles
// without mem_ack. The aborted access returns all ones and pulses err.
// When the macro is undefined, err is tied low.
//
// state_q is the FSM state register (IDLE/BUSY/RESP). Bind checkers to it.
module mem_port_arbiter #(
    parameter int AW       = 9,
    parameter int DW       = 16,
    parameter int MAX_DATA = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          d_rd_en,
    input  logic          d_wr_en,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       owner_data_q;   // 1: current access belongs to the data path
    logic [3:0] dcnt_q;         // consecutive data grants while fetch waited
    logic       d_req;
    logic       any_req;
    logic       fetch_win;
    logic       tmo_hit;

    generate
        if (MAX_DATA < 1 || MAX_DATA > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_cfg_check
            $error("mem_port_arbiter: MAX_DATA must be 1..15 and TIMEOUT 1..255");
        end
    endgenerate

    assign d_req     = d_rd_en | d_wr_en;
    assign any_req   = if_req | d_req;
    // Fetch takes the port only when no data request is present, or when
    // fetch has already waited through MAX_DATA data grants.
    assign fetch_win = if_req & (~d_req | (dcnt_q == 4'(MAX_DATA)));
    // Gate stall with rst_n so the PC is not frozen while in reset.
    assign stall     = rst_n & d_req & ~d_done;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] tcnt_q;
    logic       err_q;

    // tcnt_q is zero in the first BUSY cycle. The abort happens at the end
    // of BUSY cycle number TIMEOUT. An ack in that cycle still wins.
    assign tmo_hit = (state_q == S_BUSY) & ~mem_ack & (tcnt_q == 8'(TIMEOUT - 1));
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q  <= tmo_hit;
            if (state_q == S_BUSY) tcnt_q <= tcnt_q + 8'd1;
            else                   tcnt_q <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_BUSY;
            S_BUSY:  if (mem_ack || tmo_hit) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Starvation counter. Any cycle in which fetch is not asking wipes
    // the fetch's accumulated claim.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q <= '0;
        end else if (!if_req) begin
            dcnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            dcnt_q <= fetch_win ? 4'd0 : dcnt_q + 4'd1;
        end
    end

    // Registered datapath and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_data_q <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_done      <= 1'b0;
            d_done       <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        mem_req      <= 1'b1;
                        owner_data_q <= ~fetch_win;
                        if (fetch_win) begin
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                        end else begin
                            mem_we    <= d_wr_en;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (owner_data_q) begin
                            d_done <= 1'b1;
                            if (!mem_we) d_rdata <= mem_rdata;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else if (tmo_hit) begin
                        mem_req <= 1'b0;
                        if (owner_data_q) begin
                            d_done  <= 1'b1;
                            d_rdata <= '1;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= '1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. A behavioural memory answers mem_req after
// ack_wait extra cycles. Expected read data is queued when a request is
// driven and popped when the matching *_done pulse appears.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [8:0]  if_addr;
    logic        if_done;
    logic [15:0] if_rdata;
    logic        d_rd_en;
    logic        d_wr_en;
    logic [8:0]  d_addr;
    logic [15:0] d_wdata;
    logic        d_done;
    logic [15:0] d_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [15:0] if_exp_q[$];
    logic [15:0] d_exp_q[$];
    logic        grant_exp_q[$];   // 1 = data grant, 0 = fetch grant

    logic [15:0] model_mem [512];
    int          ack_wait = 0;
    int          wait_cnt = 0;
    bit          mute = 1'b0;
    bit          force_ack = 1'b0;
    logic [15:0] force_data = 16'h0;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
    );

    // ---------------- clock / reset / watchdog ----------------
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- memory responder ----------------
    always @(negedge clk) begin
        if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = force_data;
        end else if (mem_req && !mem_ack && !mute) begin
            if (wait_cnt >= ack_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = model_mem[mem_addr];
                if (mem_we) model_mem[mem_addr] = mem_wdata;
                wait_cnt  = 0;
            end else begin
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            mem_ack = 1'b0;
            if (!mem_req) wait_cnt = 0;
        end
    end

    task automatic wait_any_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (if_done || d_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        d_rd_en = 1'b1;
        repeat (2) @(negedge clk);
        if (stall !== 1'b0) begin $display("FAIL reset_stall: got %b want 0", stall); n_bad++; end
        n_cmp++;
        if ({mem_req, mem_we, if_done, d_done, err} !== 5'b0) begin
            $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, if_done, d_done, err}); n_bad++;
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 57'h0) begin
            $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, if_rdata, d_rdata}); n_bad++;
        end
        n_cmp++;
        d_rd_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        if (mem_req !== 1'b0) begin $display("FAIL reset_idle_req: got %b want 0", mem_req); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_fetch_only();
        logic [15:0] e;
        ack_wait = 0;
        if_req = 1'b1;
        if_addr = 9'h010;
        if_exp_q.push_back(16'h1235);
        @(negedge clk);
        if ({mem_req, mem_we} !== 2'b10) begin $display("FAIL fetch_req_we: got %b want 10", {mem_req, mem_we}); n_bad++; end
        n_cmp++;
        if (mem_addr !== 9'h010) begin $display("FAIL fetch_addr: got %h want 010", mem_addr); n_bad++; end
        n_cmp++;
        @(negedge clk);
        if (if_done !== 1'b1) begin $display("FAIL fetch_done: got %b want 1", if_done); n_bad++; end
        n_cmp++;
        e = if_exp_q.pop_front();
        if (if_rdata !== e) begin $display("FAIL fetch_rdata: got %h want %h", if_rdata, e); n_bad++; end
        n_cmp++;
        if_req = 1'b0;
        @(negedge clk);
        if (if_done !== 1'b0) begin $display("FAIL fetch_done_pulse: got %b want 0", if_done); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_store_collision();
        logic [15:0] e;
        bit ok;
        d_wr_en = 1'b1; d_addr = 9'h0A0; d_wdata = 16'hBEEF;
        if_req = 1'b1;  if_addr = 9'h020;
        if_exp_q.push_back(16'h1245);
        #1;
        if (stall !== 1'b1) begin $display("FAIL coll_stall_req: got %b want 1", stall); n_bad++; end
        n_cmp++;
        @(negedge clk);
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 9'h0A0, 16'hBEEF}) begin
            $display("FAIL coll_write_grant: got %b %b %h %h want 1 1 0a0 beef", mem_req, mem_we, mem_addr, mem_wdata); n_bad++;
        end
        n_cmp++;
        if (stall !== 1'b1) begin $display("FAIL coll_stall_busy: got %b want 1", stall); n_bad++; end
        n_cmp++;
        @(negedge clk);
        if ({d_done, stall} !== 2'b10) begin $display("FAIL coll_d_done: got done/stall %b want 10", {d_done, stall}); n_bad++; end
        n_cmp++;
        d_wr_en = 1'b0;
        repeat (2) @(negedge clk);
        if ({mem_req, mem_we, mem_addr} !== {2'b10, 9'h020}) begin
            $display("FAIL coll_fetch_next: got %b %b %h want 1 0 020", mem_req, mem_we, mem_addr); n_bad++;
        end
        n_cmp++;
        wait_any_done(10, ok);
        if (!ok || if_done !== 1'b1) begin $display("FAIL coll_fetch_done: got %b want 1", if_done); n_bad++; end
        n_cmp++;
        e = if_exp_q.pop_front();
        if (if_rdata !== e) begin $display("FAIL coll_fetch_rdata: got %h want %h", if_rdata, e); n_bad++; end
        n_cmp++;
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wait_states();
        logic [15:0] e;
        ack_wait = 2;
        d_rd_en = 1'b1; d_addr = 9'h0A0; d_wdata = 16'h1234;
        d_exp_q.push_back(16'hBEEF);   // written by the store in the collision test
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d_addr = 9'h1FF; d_wdata = 16'h0F0F;   // must be ignored while BUSY
            if ({mem_req, mem_addr, mem_wdata, d_done} !== {1'b1, 9'h0A0, 16'h1234, 1'b0}) begin
                $display("FAIL wait_stable_%0d: got %b %h %h %b want 1 0a0 1234 0", i, mem_req, mem_addr, mem_wdata, d_done); n_bad++;
            end
            n_cmp++;
        end
        @(negedge clk);
        e = d_exp_q.pop_front();
        if ({d_done, d_rdata} !== {1'b1, e}) begin $display("FAIL wait_done_rdata: got %b %h want 1 %h", d_done, d_rdata, e); n_bad++; end
        n_cmp++;
        d_rd_en = 1'b0;
        ack_wait = 0;
        @(negedge clk);
        force_data = 16'hDEAD;
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
        force_ack = 1'b0;
        repeat (2) @(negedge clk);
        if ({mem_req, if_done, d_done, d_rdata, if_rdata} !== {3'b000, 16'hBEEF, 16'h1245}) begin
            $display("FAIL stray_ack: got %b%b%b %h %h want 000 beef 1245", mem_req, if_done, d_done, d_rdata, if_rdata); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_write_priority();
        bit ok;
        d_rd_en = 1'b1; d_wr_en = 1'b1; d_addr = 9'h0B0; d_wdata = 16'h5A5A;
        @(negedge clk);
        if ({mem_we, mem_wdata} !== {1'b1, 16'h5A5A}) begin $display("FAIL wr_wins: got %b %h want 1 5a5a", mem_we, mem_wdata); n_bad++; end
        n_cmp++;
        wait_any_done(10, ok);
        if (!ok || d_done !== 1'b1 || d_rdata !== 16'hBEEF) begin
            $display("FAIL wr_keeps_rdata: got done %b rdata %h want 1 beef", d_done, d_rdata); n_bad++;
        end
        n_cmp++;
        d_rd_en = 1'b0; d_wr_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        logic [6:0]  order;
        logic [15:0] e;
        logic        g, prev_req;
        int          ndone, ngrant;
        bit          finished;
        order = 7'b1111011;
        for (int i = 6; i >= 0; i--) grant_exp_q.push_back(order[i]);
        for (int i = 0; i < 6; i++) d_exp_q.push_back(16'h1275);
        if_req = 1'b1; if_addr = 9'h100;
        d_rd_en = 1'b1; d_addr = 9'h050;
        prev_req = 1'b0; ndone = 0; ngrant = 0; finished = 1'b0;
        for (int c = 0; c < 100 && !finished; c++) begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                if (grant_exp_q.size() > 0) begin
                    g = grant_exp_q.pop_front();
                    if ((mem_addr == 9'h050) !== g) begin
                        $display("FAIL starve_grant_%0d: got data=%b want data=%b", ngrant, (mem_addr == 9'h050), g); n_bad++;
                    end
                    n_cmp++;
                end
                ngrant++;
            end
            prev_req = mem_req;
            if (d_done) begin
                e = (d_exp_q.size() > 0) ? d_exp_q.pop_front() : 16'hxxxx;
                if (d_rdata !== e) begin $display("FAIL starve_d_rdata: got %h want %h", d_rdata, e); n_bad++; end
                n_cmp++;
                ndone++;
                if (ndone == 6) d_rd_en = 1'b0;
            end
            if (if_done) begin
                if (if_rdata !== 16'h1325) begin $display("FAIL starve_if_rdata: got %h want 1325", if_rdata); n_bad++; end
                n_cmp++;
                if (ndone >= 6) begin
                    if_req = 1'b0;
                    finished = 1'b1;
                end
            end
        end
        if (!finished || grant_exp_q.size() != 0) begin
            $display("FAIL starve_complete: got %0d grants left want 0", grant_exp_q.size()); n_bad++;
        end
        n_cmp++;
        grant_exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int t[3];
        bit ok;
        logic [15:0] e;
        if_req = 1'b1; if_addr = 9'h005;
        for (int i = 0; i < 3; i++) if_exp_q.push_back(16'h122A);
        for (int i = 0; i < 3; i++) begin
            wait_any_done(10, ok);
            t[i] = cyc;
            e = if_exp_q.pop_front();
            if (!ok || if_rdata !== e) begin $display("FAIL b2b_rdata_%0d: got %h want %h", i, if_rdata, e); n_bad++; end
            n_cmp++;
        end
        if_req = 1'b0;
        if ((t[1] - t[0]) !== 3 || (t[2] - t[1]) !== 3) begin
            $display("FAIL b2b_spacing: got %0d,%0d want 3,3", t[1] - t[0], t[2] - t[1]); n_bad++;
        end
        n_cmp++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        ack_wait = 10;
        if_req = 1'b1; if_addr = 9'h030;
        repeat (2) @(negedge clk);
        if (mem_req !== 1'b1) begin $display("FAIL rstmid_busy: got %b want 1", mem_req); n_bad++; end
        n_cmp++;
        #2;
        rst_n = 1'b0;
        ack_wait = 0;
        #1;
        if ({mem_req, if_done, d_done, err, mem_addr, mem_wdata, if_rdata, d_rdata} !== 61'h0) begin
            $display("FAIL rstmid_clear: got %b %h %h %h %h want all 0", {mem_req, if_done, d_done, err}, mem_addr, mem_wdata, if_rdata, d_rdata); n_bad++;
        end
        n_cmp++;
        @(negedge clk);
        if (if_done !== 1'b0) begin $display("FAIL rstmid_no_done: got %b want 0", if_done); n_bad++; end
        n_cmp++;
        rst_n = 1'b1;
        if_exp_q.push_back(16'h1255);
        @(negedge clk);
        if ({mem_req, mem_addr} !== {1'b1, 9'h030}) begin $display("FAIL rstmid_regrant: got %b %h want 1 030", mem_req, mem_addr); n_bad++; end
        n_cmp++;
        wait_any_done(10, ok);
        if (!ok || if_rdata !== if_exp_q[0]) begin $display("FAIL rstmid_rdata: got %h want %h", if_rdata, if_exp_q[0]); n_bad++; end
        n_cmp++;
        void'(if_exp_q.pop_front());
        if_req = 1'b0;
        @(negedge clk);
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int  hi;
        bit  seen;
        mute = 1'b1;
        d_rd_en = 1'b1; d_addr = 9'h040;
        hi = 0; seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (mem_req) hi++;
            else if (hi > 0) seen = 1'b1;
        end
        if (hi !== 15) begin $display("FAIL tmo_req_len: got %0d want 15", hi); n_bad++; end
        n_cmp++;
        if ({d_done, err, d_rdata} !== {2'b11, 16'hFFFF}) begin
            $display("FAIL tmo_abort: got %b %b %h want 1 1 ffff", d_done, err, d_rdata); n_bad++;
        end
        n_cmp++;
        d_rd_en = 1'b0;
        mute = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_rd_en = 1'b0; d_wr_en = 1'b0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 512; i++) model_mem[i] = 16'h1225 + 16'(i);
        test_reset();
        test_fetch_only();
        test_store_collision();
        test_wait_states();
        test_write_priority();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
